mipi_csi_packet_ctrl: RTL and testbench

//  Sequences the CSI-2 RAW10 receive datapath. Takes 32-bit lane-aligned words (4 lanes, byte0 = data_i[7:0]).

---
 rtl/mipi_csi_packet_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mipi_csi_packet_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_packet_ctrl.sv
// CSI-2 RAW10 receive sequencer: header decode with ECC check, VC/DT filtering,
// payload gating to the unpacker, frame/line sync and counters, error pulses.
module mipi_csi_packet_ctrl #(
    parameter int WC_W      = 16,
    parameter int FCNT_W    = 16,
    parameter int ECC_CHECK = 1
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [1:0]        vc_sel_i,
    input  logic [5:0]        dt_sel_i,
    input  logic              data_valid_i,
    input  logic [31:0]       data_i,
    output logic              payload_valid_o,
    output logic [31:0]       payload_o,
    output logic              payload_last_o,
    output logic [2:0]        payload_bytes_o,
    output logic              frame_active_o,
    output logic              fsync_o,
    output logic              lsync_o,
    output logic [WC_W-1:0]   line_count_o,
    output logic [FCNT_W-1:0] frame_count_o,
    output logic              ecc_err_o,
    output logic              pkt_err_o
);

    // The header is decoded in the IDLE cycle it arrives, so no separate header state.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_SKIP,
        ST_TRAIL
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_payload_valid, w_payload_valid;
    logic [31:0]         r_payload, w_payload;
    logic                r_last, w_last;
    logic [2:0]          r_bytes, w_bytes;
    logic                r_frame_active, w_frame_active;
    logic                r_fsync, w_fsync;
    logic                r_lsync, w_lsync;
    logic [WC_W-1:0]     r_line, w_line;
    logic [FCNT_W-1:0]   r_frame, w_frame;
    logic                r_ecc_err, w_ecc_err;
    logic                r_pkt_err, w_pkt_err;
    logic [WC_W-1:0]     r_remaining, w_remaining;

    logic [1:0]          w_vc;
    logic [5:0]          w_dt;
    logic [WC_W-1:0]     w_wc;
    logic                w_ecc_ok;

    function automatic logic [5:0] csiEcc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    assign w_vc = data_i[7:6];
    assign w_dt = data_i[5:0];
    assign w_wc = WC_W'(data_i[23:8]);
    // Reserved ECC bits [7:6] must be zero, so the whole top byte is compared.
    assign w_ecc_ok = (ECC_CHECK == 0) || (data_i[31:24] == {2'b00, csiEcc(data_i[23:0])});

    always_comb begin
        w_state_nxt     = r_state;
        w_payload_valid = 1'b0;
        w_payload       = r_payload;
        w_last          = 1'b0;
        w_bytes         = 3'd0;
        w_frame_active  = r_frame_active;
        w_fsync         = 1'b0;
        w_lsync         = r_lsync;
        w_line          = r_line;
        w_frame         = r_frame;
        w_ecc_err       = 1'b0;
        w_pkt_err       = 1'b0;
        w_remaining     = r_remaining;

        case (r_state)
            ST_IDLE: begin
                if (data_valid_i) begin
                    w_state_nxt = ST_TRAIL;
                    if (!enable_i) begin
                        w_state_nxt = ST_TRAIL;
                    end else if (!w_ecc_ok) begin
                        w_ecc_err = 1'b1;
                    end else if (w_vc != vc_sel_i) begin
                        w_state_nxt = ST_TRAIL;
                    end else if (w_dt < 6'h10) begin
                        if (w_dt == 6'h00) begin
                            w_fsync        = 1'b1;
                            w_frame_active = 1'b1;
                            w_line         = '0;
                        end else if (w_dt == 6'h01 && r_frame_active) begin
                            w_frame_active = 1'b0;
                            w_frame        = r_frame + FCNT_W'(1);
                        end
                    end else if (w_wc != '0) begin
                        w_remaining = w_wc;
                        if (w_dt == dt_sel_i) begin
                            w_state_nxt = ST_PAYLOAD;
                            w_lsync     = 1'b1;
                        end else begin
                            w_state_nxt = ST_SKIP;
                        end
                    end
                end
            end

            ST_PAYLOAD, ST_SKIP: begin
                if (data_valid_i) begin
                    if (r_state == ST_PAYLOAD) begin
                        w_payload_valid = 1'b1;
                        w_payload       = data_i;
                    end
                    if (r_remaining <= WC_W'(4)) begin
                        w_remaining = '0;
                        w_state_nxt = ST_TRAIL;
                        if (r_state == ST_PAYLOAD) begin
                            w_last  = 1'b1;
                            w_bytes = r_remaining[2:0];
                            w_lsync = 1'b0;
                            w_line  = r_line + WC_W'(1);
                        end
                    end else begin
                        w_remaining = r_remaining - WC_W'(4);
                    end
                end else begin
                    // Burst ended early: abort without a last beat or line increment.
                    w_pkt_err   = 1'b1;
                    w_lsync     = 1'b0;
                    w_remaining = '0;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_TRAIL: begin
                if (!data_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_payload_valid <= 1'b0;
            r_payload       <= '0;
            r_last          <= 1'b0;
            r_bytes         <= '0;
            r_frame_active  <= 1'b0;
            r_fsync         <= 1'b0;
            r_lsync         <= 1'b0;
            r_line          <= '0;
            r_frame         <= '0;
            r_ecc_err       <= 1'b0;
            r_pkt_err       <= 1'b0;
            r_remaining     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_payload_valid <= w_payload_valid;
            r_payload       <= w_payload;
            r_last          <= w_last;
            r_bytes         <= w_bytes;
            r_frame_active  <= w_frame_active;
            r_fsync         <= w_fsync;
            r_lsync         <= w_lsync;
            r_line          <= w_line;
            r_frame         <= w_frame;
            r_ecc_err       <= w_ecc_err;
            r_pkt_err       <= w_pkt_err;
            r_remaining     <= w_remaining;
        end
    end

    assign payload_valid_o = r_payload_valid;
    assign payload_o       = r_payload;
    assign payload_last_o  = r_last;
    assign payload_bytes_o = r_bytes;
    assign frame_active_o  = r_frame_active;
    assign fsync_o         = r_fsync;
    assign lsync_o         = r_lsync;
    assign line_count_o    = r_line;
    assign frame_count_o   = r_frame;
    assign ecc_err_o       = r_ecc_err;
    assign pkt_err_o       = r_pkt_err;

endmodule

// File: tb/tb_mipi_csi_packet_ctrl.sv
// Directed table-driven bench for mipi_csi_packet_ctrl; headers and ECC bytes
// are hand-computed, plus hand-written sequences for enable and reset corners.
module tb_mipi_csi_packet_ctrl;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        enable_i;
    logic [1:0]  vc_sel_i;
    logic [5:0]  dt_sel_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        payload_valid_o;
    logic [31:0] payload_o;
    logic        payload_last_o;
    logic [2:0]  payload_bytes_o;
    logic        frame_active_o;
    logic        fsync_o;
    logic        lsync_o;
    logic [15:0] line_count_o;
    logic [15:0] frame_count_o;
    logic        ecc_err_o;
    logic        pkt_err_o;

    int checkCount = 0;
    int passCount  = 0;

    mipi_csi_packet_ctrl dut (
        .clk_i           (clk_i),
        .reset           (reset),
        .enable_i        (enable_i),
        .vc_sel_i        (vc_sel_i),
        .dt_sel_i        (dt_sel_i),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .payload_valid_o (payload_valid_o),
        .payload_o       (payload_o),
        .payload_last_o  (payload_last_o),
        .payload_bytes_o (payload_bytes_o),
        .frame_active_o  (frame_active_o),
        .fsync_o         (fsync_o),
        .lsync_o         (lsync_o),
        .line_count_o    (line_count_o),
        .frame_count_o   (frame_count_o),
        .ecc_err_o       (ecc_err_o),
        .pkt_err_o       (pkt_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        dv;
        logic [31:0] data;
        logic        pv;
        logic [31:0] pay;
        logic        last;
        logic [2:0]  bytes;
        logic        lsync;
        logic        fsync;
        logic        fa;
        logic        ecc;
        logic        perr;
        logic [15:0] line;
        logic [15:0] fcnt;
    } vec_t;

    vec_t tbl[$];

    // Hand-computed headers: {ECC, WC hi, WC lo, DI}
    localparam logic [31:0] HDR_FS      = 32'h0000_0000;
    localparam logic [31:0] HDR_FE      = 32'h0700_0001;
    localparam logic [31:0] HDR_FS_BAD  = 32'h0100_0000;
    localparam logic [31:0] HDR_RAW_10  = 32'h2E00_0A2B;
    localparam logic [31:0] HDR_RAW_4   = 32'h3400_042B;
    localparam logic [31:0] HDR_RAW_0   = 32'h1700_002B;
    localparam logic [31:0] HDR_DT2A_8  = 32'h3500_082A;
    localparam logic [31:0] HDR_VC1_8   = 32'h2400_086B;

    function automatic vec_t mk(input logic dv, input logic [31:0] data,
                                input logic pv, input logic [31:0] pay,
                                input logic last, input logic [2:0] bytes,
                                input logic lsync, input logic fsync, input logic fa,
                                input logic ecc, input logic perr,
                                input logic [15:0] line, input logic [15:0] fcnt);
        vec_t v;
        v.dv = dv; v.data = data; v.pv = pv; v.pay = pay; v.last = last;
        v.bytes = bytes; v.lsync = lsync; v.fsync = fsync; v.fa = fa;
        v.ecc = ecc; v.perr = perr; v.line = line; v.fcnt = fcnt;
        return v;
    endfunction

    // Drive one cycle of input and return just after the edge that registers it.
    task automatic applyStimulus(input logic v, input logic [31:0] d);
        @(negedge clk_i);
        data_valid_i = v;
        data_i       = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        else
            passCount++;
    endtask

    task automatic checkVector(input int step, input vec_t v);
        checkOutput("payload_valid", step, 32'(payload_valid_o), 32'(v.pv));
        if (v.pv)
            checkOutput("payload", step, payload_o, v.pay);
        checkOutput("payload_last",  step, 32'(payload_last_o),  32'(v.last));
        checkOutput("payload_bytes", step, 32'(payload_bytes_o), 32'(v.bytes));
        checkOutput("lsync",         step, 32'(lsync_o),         32'(v.lsync));
        checkOutput("fsync",         step, 32'(fsync_o),         32'(v.fsync));
        checkOutput("frame_active",  step, 32'(frame_active_o),  32'(v.fa));
        checkOutput("ecc_err",       step, 32'(ecc_err_o),       32'(v.ecc));
        checkOutput("pkt_err",       step, 32'(pkt_err_o),       32'(v.perr));
        checkOutput("line_count",    step, 32'(line_count_o),    32'(v.line));
        checkOutput("frame_count",   step, 32'(frame_count_o),   32'(v.fcnt));
    endtask

    initial begin
        int beats;
        vec_t zero;
        reset        = 1'b1;
        enable_i     = 1'b1;
        vc_sel_i     = 2'd0;
        dt_sel_i     = 6'h2B;
        data_valid_i = 1'b0;
        data_i       = '0;

        //          dv  data         pv  pay          lst byt ls fs fa ec pe line fcnt
        tbl.push_back(mk(1, HDR_FS,      0, 0,           0, 0, 0, 1, 1, 0, 0, 0, 0)); // 0 FS
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, HDR_RAW_10,  0, 0,           0, 0, 1, 0, 1, 0, 0, 0, 0)); // 2 RAW10 WC=10
        tbl.push_back(mk(1, 32'h11223344, 1, 32'h11223344, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h55667788, 1, 32'h55667788, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h99AABBCC, 1, 32'h99AABBCC, 1, 2, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h0000DEAD, 0, 0,          0, 0, 0, 0, 1, 0, 0, 1, 0)); // CRC
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, HDR_FE,      0, 0,           0, 0, 0, 0, 0, 0, 0, 1, 1)); // 8 FE
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, HDR_FE,      0, 0,           0, 0, 0, 0, 0, 0, 0, 1, 1)); // 10 FE, no frame
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, HDR_FS_BAD,  0, 0,           0, 0, 0, 0, 0, 1, 0, 1, 1)); // 12 bad ECC
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, HDR_FS,      0, 0,           0, 0, 0, 1, 1, 0, 0, 0, 1)); // 14 good FS
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, HDR_DT2A_8,  0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1)); // 16 DT 2A skip
        tbl.push_back(mk(1, 32'hA1A2A3A4, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'hB1B2B3B4, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0000BEEF, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, HDR_VC1_8,   0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1)); // 21 VC1 filtered
        tbl.push_back(mk(1, 32'hC1C2C3C4, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'hD1D2D3D4, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0000BEEF, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, HDR_RAW_0,   0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1)); // 26 WC=0
        tbl.push_back(mk(1, 32'h0000BEEF, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, HDR_RAW_4,   0, 0,           0, 0, 1, 0, 1, 0, 0, 0, 1)); // 29 WC=4
        tbl.push_back(mk(1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 4, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, HDR_RAW_10,  0, 0,           0, 0, 1, 0, 1, 0, 0, 1, 1)); // 32 early drop
        tbl.push_back(mk(1, 32'h01020304, 1, 32'h01020304, 0, 0, 1, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0,           0, 0,           0, 0, 0, 0, 1, 0, 0, 1, 1));

        repeat (2) @(posedge clk_i);
        #1;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVector(-1, zero);
        @(negedge clk_i);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].dv, tbl[i].data);
            checkVector(i, tbl[i]);
        end

        // enable_i dropped after the header: the packet still completes
        applyStimulus(1'b1, HDR_RAW_10);
        checkOutput("en_mid_lsync", 100, 32'(lsync_o), 32'd1);
        enable_i = 1'b0;
        beats = 0;
        applyStimulus(1'b1, 32'h0A0B0C0D); beats += int'(payload_valid_o);
        applyStimulus(1'b1, 32'h1A1B1C1D); beats += int'(payload_valid_o);
        applyStimulus(1'b1, 32'h2A2B2C2D); beats += int'(payload_valid_o);
        checkOutput("en_mid_beats", 101, 32'(beats), 32'd3);
        checkOutput("en_mid_last",  102, 32'(payload_last_o), 32'd1);
        checkOutput("en_mid_bytes", 103, 32'(payload_bytes_o), 32'd2);
        checkOutput("en_mid_line",  104, 32'(line_count_o), 32'd2);
        applyStimulus(1'b0, 32'h0);

        // Packet arriving while disabled is not accepted
        applyStimulus(1'b1, HDR_FS);
        checkOutput("dis_fsync", 105, 32'(fsync_o), 32'd0);
        checkOutput("dis_line",  106, 32'(line_count_o), 32'd2);
        applyStimulus(1'b0, 32'h0);
        enable_i = 1'b1;

        // Reset asserted mid-payload clears everything, with no error pulse
        applyStimulus(1'b1, HDR_RAW_10);
        applyStimulus(1'b1, 32'h12345678);
        checkOutput("rst_pre_pv", 107, 32'(payload_valid_o), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h9ABCDEF0);
        checkVector(108, zero);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("rst_post_perr", 109, 32'(pkt_err_o), 32'd0);
        checkOutput("rst_post_pv",   110, 32'(payload_valid_o), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
